fantasticfft_fftn_iter: RTL and testbench
=========================================

// Module: fantasticfft_fftn_iter
// PURPOSE
//  Parametrised N-point radix-2 DIT FFT on complex fixed-point data. It generalises the fixed
//  8-point real-input FFT to any power-of-two N and complex input, with selectable scaling.
//  A single iterative butterfly engine runs over an internal register array.
//  Frames stream in and out over valid/ready handshakes. Sits between the sample front end
//  and the spectrum consumer in the fantasticfft datapath.
// PARAMETERS
//  N_POINTS  8  transform size; power of two, 4..64
//  INT_W     8  integer bits incl. sign (data is signed Q(INT_W).(FRAC_W))
//  FRAC_W    8  fraction bits; W = INT_W+FRAC_W, LG = $clog2(N_POINTS)
//  SCALE_EN  0  1: each stage result >>>1 (total 1/N); 0: saturate + flag overflow
// PORTS
//  clk        in   1    rising-edge clock
//  rst_n      in   1    asynchronous active-low reset
//  in_valid   in   1    input sample valid
//  in_ready   out  1    block accepts a sample (high only in LOAD)
//  in_re      in   W    input real part, signed fixed point
//  in_im      in   W    input imaginary part
//  out_valid  out  1    output bin valid (high only in UNLOAD)
//  out_ready  in   1    consumer accepts bin
//  out_re     out  W    bin real part
//  out_im     out  W    bin imaginary part
//  out_index  out  LG   bin number, natural order 0..N-1
//  out_last   out  1    high with bin N-1
//  busy       out  1    high in COMPUTE or UNLOAD
//  ovf        out  1    sticky: a saturation occurred in the current frame
// BEHAVIOUR
//  Reset (async, rst_n=0): state=LOAD, counters=0, all outputs 0 incl. in_ready; array contents don't-care.
//  States: LOAD -> COMPUTE -> UNLOAD -> LOAD.
//   LOAD: in_ready=1. Sample k is stored at bitrev(k) on each edge with in_valid&in_ready.
//    The edge accepting sample N-1 moves to COMPUTE. First accept of a frame clears ovf.
//   COMPUTE: one butterfly per edge, in stage s=0..LG-1, butterfly b=0..N/2-1, b fastest.
//    h=2^s; top=(b>>s)*2h+(b&(h-1)); bot=top+h; k=(b&(h-1))*(N/(2h)).
//    Tw=cos(2pi*k/N) - j*sin(2pi*k/N), from a Q1.FRAC_W ROM built at elaboration, rounded to nearest.
//    P=Tw*A[bot]: full 2W products, summed, round-half-up to FRAC_W.
//    A[top]=A[top]+P; A[bot]=A[top]-P. Both are computed at W+1 bits, then:
//     SCALE_EN=1: arithmetic shift right 1 (truncate), no overflow possible;
//     SCALE_EN=0: saturate to [-2^(W-1), 2^(W-1)-1]; any clip sets ovf.
//    Read and write of both operands happen on the same edge. Exactly N/2*LG edges, then UNLOAD.
//    out_valid is visible after the N/2*LG-th edge following the last input accept (N=8: 12).
//   UNLOAD: out_valid=1 and out_re/out_im=A[idx], out_index=idx, idx starting at 0.
//    idx advances only on out_valid&out_ready; outputs hold stable while out_ready=0.
//    The transfer with out_last=1 returns to LOAD; out_valid drops the same edge.
//  in_valid outside LOAD is ignored (no storage, no state change); out_ready outside UNLOAD is ignored.
//  ovf holds through UNLOAD and is readable until the next frame's first accept.
//  rst_n low mid-frame aborts immediately. The next frame after release is computed from scratch.
// TESTING (N=8, Q8.8 unless stated; tolerance +/-2 LSB on twiddled bins)
//  1 Impulse: x0=1.0 (0x0100), x1..7=0, SCALE_EN=0 -> all 8 bins re=0x0100, im=0, ovf=0.
//  2 Ramp: x=1..8 real, SCALE_EN=0 -> X0=36.0 (0x2400).
//    X4=-4.0 (0xFC00). X2=-4+j4. X1=-4+j9.657 (im ~0x09A8). X7=conj(X1).
//    out_valid exactly 12 edges after the last accept; out_index runs 0..7, out_last on 7.
//  3 Same ramp, SCALE_EN=1 -> X0=4.5 (0x0480), X4=-0.5 (0xFF80), ovf=0.
//  4 Overflow: all x=127.0, SCALE_EN=0 -> X0=0x7FFF, ovf=1. The next impulse frame clears ovf to 0.
//  5 Backpressure: out_ready random 50% and in_valid gaps -> each bin delivered once, in order, with correct value.
//    in_valid pulses during COMPUTE/UNLOAD are not absorbed.
//  6 Reset mid-COMPUTE (edge 5) -> all outputs 0 at once; a following ramp frame matches scenario 2.

Source files
------------

// File: rtl/fantasticfft_fftn_iter.sv
// Iterative N-point radix-2 DIT FFT on complex fixed-point samples: load in bit-reversed order,
// run one butterfly per clock over an internal register array, then unload bins in natural order.
module fantasticfft_fftn_iter #(
    parameter int unsigned N_POINTS = 8,
    parameter int unsigned INT_W    = 8,
    parameter int unsigned FRAC_W   = 8,
    parameter bit          SCALE_EN = 1'b0,
    localparam int unsigned W       = INT_W + FRAC_W,
    localparam int unsigned LG      = $clog2(N_POINTS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_re,
    input  logic [W-1:0]  in_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_re,
    output logic [W-1:0]  out_im,
    output logic [LG-1:0] out_index,
    output logic          out_last,
    output logic          busy,
    output logic          ovf
);

    localparam int unsigned TW_W = FRAC_W + 2;
    localparam int unsigned PW   = W + TW_W + 1;
    localparam int unsigned SW   = W + 4;
    localparam real Pi    = 3.14159265358979323846;
    localparam real Scale = 2.0 ** FRAC_W;
    localparam logic signed [PW-1:0] Half   = PW'(1 << (FRAC_W - 1));
    localparam logic signed [SW-1:0] SatMax = SW'({1'b0, {(W - 1){1'b1}}});
    localparam logic signed [SW-1:0] SatMin = ~SatMax;

    typedef enum logic [1:0] {StLoad, StCompute, StUnload} state_e;

    state_e state_q, state_d;
    logic [LG-1:0] in_cnt_q, in_cnt_d, stage_q, stage_d, bfly_q, bfly_d, idx_q, idx_d;
    logic ovf_q, ovf_d, in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic busy_q, busy_d, out_last_q, out_last_d;
    logic [W-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
    logic [LG-1:0] out_index_q, out_index_d;

    logic signed [W-1:0] mem_re_q [N_POINTS];
    logic signed [W-1:0] mem_im_q [N_POINTS];
    logic signed [W-1:0] mem_re_d [N_POINTS];
    logic signed [W-1:0] mem_im_d [N_POINTS];

    // Twiddle ROM, W^k = cos - j*sin, rounded to nearest at elaboration.
    logic signed [TW_W-1:0] tw_re [N_POINTS/2];
    logic signed [TW_W-1:0] tw_im [N_POINTS/2];

    for (genvar gk = 0; gk < N_POINTS / 2; gk++) begin : g_tw
        localparam real Ang = 2.0 * Pi * gk / N_POINTS;
        localparam real Cr  = $cos(Ang) * Scale;
        localparam real Ci  = -$sin(Ang) * Scale;
        localparam int  CrI = (Cr >= 0.0) ? $rtoi(Cr + 0.5) : -$rtoi(0.5 - Cr);
        localparam int  CiI = (Ci >= 0.0) ? $rtoi(Ci + 0.5) : -$rtoi(0.5 - Ci);
        assign tw_re[gk] = TW_W'(CrI);
        assign tw_im[gk] = TW_W'(CiI);
    end

    function automatic logic [LG-1:0] bitrev(input logic [LG-1:0] v);
        logic [LG-1:0] r;
        for (int i = 0; i < LG; i++) r[i] = v[LG-1-i];
        return r;
    endfunction

    // Returns {clip, value}: halve in scaling mode, otherwise saturate to W bits.
    function automatic logic [W:0] fit(input logic signed [SW-1:0] v);
        logic [W:0] r;
        if (SCALE_EN) r = {1'b0, v[W:1]};
        else if (v > SatMax) r = {1'b1, SatMax[W-1:0]};
        else if (v < SatMin) r = {1'b1, SatMin[W-1:0]};
        else r = {1'b0, v[W-1:0]};
        return r;
    endfunction

    logic [LG-1:0] mask, top, bot;
    logic [LG-2:0] tw_idx;
    logic signed [TW_W-1:0] tw_re_k, tw_im_k;
    logic signed [W-1:0] a_re, a_im, b_re, b_im;
    logic signed [PW-1:0] pr_full, pi_full;
    logic signed [PW-FRAC_W-1:0] p_re, p_im;
    logic signed [SW-1:0] sum_re, sum_im, dif_re, dif_im;
    logic [W:0] fit_tr, fit_ti, fit_br, fit_bi;

    always_comb begin
        mask    = (LG'(1) << stage_q) - LG'(1);
        top     = ((bfly_q >> stage_q) << (stage_q + LG'(1))) | (bfly_q & mask);
        bot     = top | (LG'(1) << stage_q);
        tw_idx  = (LG-1)'((bfly_q & mask) << (LG'(LG - 1) - stage_q));
        tw_re_k = tw_re[tw_idx];
        tw_im_k = tw_im[tw_idx];
        a_re    = mem_re_q[top];
        a_im    = mem_im_q[top];
        b_re    = mem_re_q[bot];
        b_im    = mem_im_q[bot];
        pr_full = PW'(tw_re_k) * PW'(b_re) - PW'(tw_im_k) * PW'(b_im);
        pi_full = PW'(tw_re_k) * PW'(b_im) + PW'(tw_im_k) * PW'(b_re);
        p_re    = (PW-FRAC_W)'((pr_full + Half) >>> FRAC_W);
        p_im    = (PW-FRAC_W)'((pi_full + Half) >>> FRAC_W);
        sum_re  = SW'(a_re) + SW'(p_re);
        sum_im  = SW'(a_im) + SW'(p_im);
        dif_re  = SW'(a_re) - SW'(p_re);
        dif_im  = SW'(a_im) - SW'(p_im);
        fit_tr  = fit(sum_re);
        fit_ti  = fit(sum_im);
        fit_br  = fit(dif_re);
        fit_bi  = fit(dif_im);
    end

    always_comb begin
        state_d  = state_q;
        in_cnt_d = in_cnt_q;
        stage_d  = stage_q;
        bfly_d   = bfly_q;
        idx_d    = idx_q;
        ovf_d    = ovf_q;
        mem_re_d = mem_re_q;
        mem_im_d = mem_im_q;
        unique case (state_q)
            StLoad: begin
                if (in_valid && in_ready_q) begin
                    mem_re_d[bitrev(in_cnt_q)] = in_re;
                    mem_im_d[bitrev(in_cnt_q)] = in_im;
                    if (in_cnt_q == '0) ovf_d = 1'b0;
                    if (in_cnt_q == LG'(N_POINTS - 1)) begin
                        in_cnt_d = '0;
                        state_d  = StCompute;
                    end else begin
                        in_cnt_d = in_cnt_q + 1'b1;
                    end
                end
            end
            StCompute: begin
                mem_re_d[top] = fit_tr[W-1:0];
                mem_im_d[top] = fit_ti[W-1:0];
                mem_re_d[bot] = fit_br[W-1:0];
                mem_im_d[bot] = fit_bi[W-1:0];
                ovf_d = ovf_q | fit_tr[W] | fit_ti[W] | fit_br[W] | fit_bi[W];
                if (bfly_q == LG'(N_POINTS / 2 - 1)) begin
                    bfly_d = '0;
                    if (stage_q == LG'(LG - 1)) begin
                        stage_d = '0;
                        state_d = StUnload;
                    end else begin
                        stage_d = stage_q + 1'b1;
                    end
                end else begin
                    bfly_d = bfly_q + 1'b1;
                end
            end
            StUnload: begin
                if (out_valid_q && out_ready) begin
                    if (idx_q == LG'(N_POINTS - 1)) begin
                        idx_d   = '0;
                        state_d = StLoad;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = StLoad;
        endcase

        // Outputs are registered from next state so they change on the same edge as the state.
        in_ready_d  = (state_d == StLoad);
        busy_d      = (state_d != StLoad);
        out_valid_d = (state_d == StUnload);
        out_re_d    = '0;
        out_im_d    = '0;
        out_index_d = '0;
        out_last_d  = 1'b0;
        if (state_d == StUnload) begin
            out_re_d    = mem_re_d[idx_d];
            out_im_d    = mem_im_d[idx_d];
            out_index_d = idx_d;
            out_last_d  = (idx_d == LG'(N_POINTS - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StLoad;
            in_cnt_q    <= '0;
            stage_q     <= '0;
            bfly_q      <= '0;
            idx_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            stage_q     <= stage_d;
            bfly_q      <= bfly_d;
            idx_q       <= idx_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
        end
    end

    // Sample array needs no reset: every frame overwrites all entries before use.
    always_ff @(posedge clk) begin
        mem_re_q <= mem_re_d;
        mem_im_q <= mem_im_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fantasticfft_fftn_iter.sv
// Bench for the 8-point Q8.8 FFT: one unscaled and one scaled instance fed identical frames,
// spec-constant vector table plus randomized frames against a fixed-point FFT reference.
module tb_fantasticfft_fftn_iter;

    localparam int N  = 8;
    localparam int W  = 16;
    localparam int LG = 3;
    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [W-1:0] in_re = '0;
    logic [W-1:0] in_im = '0;

    logic in_ready0, out_valid0, out_last0, busy0, ovf0;
    logic in_ready1, out_valid1, out_last1, busy1, ovf1;
    logic [W-1:0] out_re0, out_im0, out_re1, out_im1;
    logic [LG-1:0] out_index0, out_index1;

    fantasticfft_fftn_iter #(.N_POINTS(8), .INT_W(8), .FRAC_W(8), .SCALE_EN(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_re(in_re), .in_im(in_im), .out_valid(out_valid0), .out_ready(out_ready),
        .out_re(out_re0), .out_im(out_im0), .out_index(out_index0), .out_last(out_last0),
        .busy(busy0), .ovf(ovf0)
    );

    fantasticfft_fftn_iter #(.N_POINTS(8), .INT_W(8), .FRAC_W(8), .SCALE_EN(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_re(in_re), .in_im(in_im), .out_valid(out_valid1), .out_ready(out_ready),
        .out_re(out_re1), .out_im(out_im1), .out_index(out_index1), .out_last(out_last1),
        .busy(busy1), .ovf(ovf1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int scen;
        int dut;
        int bin;
        int exp_re;
        int exp_im;
        int tol;
    } vec_t;

    int n_tests = 0;
    int n_fail = 0;
    int frame_re[N], frame_im[N];
    int got_re[2][N], got_im[2][N];
    int got_ovf[2];
    longint mdl_re[2][N], mdl_im[2][N];
    int mdl_ovf[2];
    int res_re[5][2][N], res_im[5][2][N];
    int res_ovf[5][2];
    vec_t tbl[$];

    task automatic check(input string name, input longint act, input longint exp, input int tol);
        n_tests++;
        if (act > exp + tol || act < exp - tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (+/-%0d)", name, act, exp, tol);
        end
    endtask

    function automatic void add(input int s, input int d, input int b, input int re, input int im,
                                input int tol);
        vec_t v;
        v.scen = s; v.dut = d; v.bin = b; v.exp_re = re; v.exp_im = im; v.tol = tol;
        tbl.push_back(v);
    endfunction

    function automatic longint rnd(input real v);
        return (v >= 0.0) ? longint'($rtoi(v + 0.5)) : -longint'($rtoi(0.5 - v));
    endfunction

    function automatic int brev(input int k);
        int r = 0;
        for (int i = 0; i < LG; i++) if (k[i]) r |= 1 << (LG - 1 - i);
        return r;
    endfunction

    function automatic longint fix(input longint v, input int sc, output bit clip);
        clip = 1'b0;
        if (sc != 0) return longint'(shortint'(v >>> 1));
        if (v > 32767) begin clip = 1'b1; return 32767; end
        if (v < -32768) begin clip = 1'b1; return -32768; end
        return v;
    endfunction

    // Fixed-point radix-2 DIT FFT straight from the stage/butterfly/twiddle rules.
    task automatic model();
        longint ar[N], ai[N];
        longint wr, wi, pr, pim, tr, ti, ur, ui;
        int h, top, bot, k;
        bit c0, c1, c2, c3;
        for (int sc = 0; sc < 2; sc++) begin
            for (int n = 0; n < N; n++) begin
                ar[brev(n)] = frame_re[n];
                ai[brev(n)] = frame_im[n];
            end
            mdl_ovf[sc] = 0;
            for (int s = 0; s < LG; s++) begin
                h = 1 << s;
                for (int b = 0; b < N / 2; b++) begin
                    top = (b >> s) * 2 * h + (b & (h - 1));
                    bot = top + h;
                    k   = (b & (h - 1)) * (N / (2 * h));
                    wr  = rnd($cos(2.0 * PI * k / N) * 256.0);
                    wi  = rnd(-$sin(2.0 * PI * k / N) * 256.0);
                    pr  = (wr * ar[bot] - wi * ai[bot] + 128) >>> 8;
                    pim = (wr * ai[bot] + wi * ar[bot] + 128) >>> 8;
                    tr  = fix(ar[top] + pr, sc, c0);
                    ti  = fix(ai[top] + pim, sc, c1);
                    ur  = fix(ar[top] - pr, sc, c2);
                    ui  = fix(ai[top] - pim, sc, c3);
                    ar[top] = tr; ai[top] = ti; ar[bot] = ur; ai[bot] = ui;
                    if (c0 || c1 || c2 || c3) mdl_ovf[sc] = 1;
                end
            end
            for (int n = 0; n < N; n++) begin
                mdl_re[sc][n] = ar[n];
                mdl_im[sc][n] = ai[n];
            end
        end
    endtask

    task automatic load_frame(input bit gaps);
        int wt;
        for (int k = 0; k < N; k++) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            in_valid = 1'b1;
            in_re = W'(frame_re[k]);
            in_im = W'(frame_im[k]);
            wt = 0;
            while (!in_ready0 && wt < 50) begin
                @(negedge clk);
                wt++;
            end
            if (!in_ready0) check("load_timeout", 0, 1, 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic collect(input bit bp, input bit junk, input string tag);
        int lat, cnt, wt;
        bit held;
        logic [W-1:0] h_re;
        logic [LG-1:0] h_idx;
        lat = 0;
        check({tag, ".busy"}, busy0, 1, 0);
        check({tag, ".in_ready_compute"}, in_ready0, 0, 0);
        while (!out_valid0 && lat < 100) begin
            if (junk) begin
                in_valid = 1'($urandom);
                in_re = W'($urandom);
                in_im = W'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, lat, 12, 0);
        cnt = 0; wt = 0; held = 1'b0; h_re = '0; h_idx = '0;
        while (cnt < N && wt < 400) begin
            check({tag, ".out_valid"}, out_valid0, 1, 0);
            if (held) begin
                check({tag, ".hold_re"}, out_re0, h_re, 0);
                check({tag, ".hold_idx"}, out_index0, h_idx, 0);
            end
            out_ready = bp ? 1'($urandom) : 1'b1;
            in_valid = (junk && out_index0 != LG'(N - 1)) ? 1'($urandom) : 1'b0;
            if (out_ready) begin
                check({tag, ".index"}, out_index0, cnt, 0);
                check({tag, ".last"}, out_last0, (cnt == N - 1) ? 1 : 0, 0);
                got_re[0][cnt] = $signed(out_re0);
                got_im[0][cnt] = $signed(out_im0);
                got_re[1][cnt] = $signed(out_re1);
                got_im[1][cnt] = $signed(out_im1);
                if (cnt == 0) begin
                    got_ovf[0] = ovf0;
                    got_ovf[1] = ovf1;
                end
                cnt++;
                held = 1'b0;
            end else begin
                held = 1'b1;
                h_re = out_re0;
                h_idx = out_index0;
            end
            @(negedge clk);
            wt++;
        end
        out_ready = 1'b0;
        in_valid = 1'b0;
        check({tag, ".bins"}, cnt, N, 0);
        check({tag, ".valid_drop"}, out_valid0, 0, 0);
        check({tag, ".in_ready_back"}, in_ready0, 1, 0);
    endtask

    task automatic run_frame(input string tag, input bit gaps, input bit bp, input bit junk);
        model();
        load_frame(gaps);
        collect(bp, junk, tag);
        for (int d = 0; d < 2; d++) begin
            for (int b = 0; b < N; b++) begin
                check($sformatf("%s.d%0d.re%0d", tag, d, b), got_re[d][b], mdl_re[d][b], 0);
                check($sformatf("%s.d%0d.im%0d", tag, d, b), got_im[d][b], mdl_im[d][b], 0);
            end
            check($sformatf("%s.d%0d.ovf", tag, d), got_ovf[d], mdl_ovf[d], 0);
        end
    endtask

    task automatic save(input int s);
        for (int d = 0; d < 2; d++) begin
            for (int b = 0; b < N; b++) begin
                res_re[s][d][b] = got_re[d][b];
                res_im[s][d][b] = got_im[d][b];
            end
            res_ovf[s][d] = got_ovf[d];
        end
    endtask

    task automatic set_impulse();
        for (int k = 0; k < N; k++) begin frame_re[k] = (k == 0) ? 256 : 0; frame_im[k] = 0; end
    endtask

    task automatic set_ramp();
        for (int k = 0; k < N; k++) begin frame_re[k] = (k + 1) * 256; frame_im[k] = 0; end
    endtask

    task automatic set_full();
        for (int k = 0; k < N; k++) begin frame_re[k] = 32512; frame_im[k] = 0; end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Spec constants: impulse, ramp (scaled and unscaled), overflow, post-reset ramp.
        for (int b = 0; b < N; b++) begin
            add(0, 0, b, 256, 0, 0);
            add(0, 1, b, 32, 0, 0);
        end
        for (int s = 1; s <= 4; s += 3) begin
            add(s, 0, 0, 9216, 0, 0);
            add(s, 0, 4, -1024, 0, 0);
            add(s, 0, 2, -1024, 1024, 2);
            add(s, 0, 6, -1024, -1024, 2);
            add(s, 0, 1, -1024, 2472, 2);
            add(s, 0, 7, -1024, -2472, 2);
            add(s, 0, 3, -1024, 424, 2);
            add(s, 1, 0, 1152, 0, 0);
            add(s, 1, 4, -128, 0, 0);
        end
        add(2, 0, 0, 32767, 0, 0);
        add(2, 1, 0, 32512, 0, 0);
        add(3, 0, 0, 256, 0, 0);
        add(3, 0, 5, 256, 0, 0);

        repeat (3) @(negedge clk);
        check("rst.in_ready", in_ready0, 0, 0);
        check("rst.out_valid", out_valid0, 0, 0);
        check("rst.busy", busy0, 0, 0);
        check("rst.ovf", ovf0, 0, 0);
        check("rst.out_re", out_re0, 0, 0);
        check("rst.out_index", out_index0, 0, 0);
        check("rst.out_last", out_last0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        set_impulse(); run_frame("impulse", 1'b0, 1'b0, 1'b0); save(0);
        set_ramp();    run_frame("ramp", 1'b0, 1'b0, 1'b0);    save(1);
        set_full();    run_frame("ovf", 1'b0, 1'b0, 1'b0);     save(2);
        check("ovf.readable_in_load", ovf0, 1, 0);
        set_impulse(); run_frame("impulse2", 1'b0, 1'b0, 1'b0); save(3);
        check("impulse2.ovf_cleared", ovf0, 0, 0);

        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < N; k++) begin
                if (f < 3) begin
                    frame_re[k] = int'($urandom_range(0, 4095)) - 2048;
                    frame_im[k] = int'($urandom_range(0, 4095)) - 2048;
                end else begin
                    frame_re[k] = int'($urandom_range(0, 32767)) - 16384;
                    frame_im[k] = int'($urandom_range(0, 32767)) - 16384;
                end
            end
            run_frame($sformatf("rand%0d", f), 1'b1, 1'b1, 1'b1);
        end

        // Abort five butterflies into an overflowing frame.
        set_full();
        load_frame(1'b0);
        repeat (5) @(negedge clk);
        check("abort.busy_before", busy0, 1, 0);
        check("abort.ovf_before", ovf0, 1, 0);
        rst_n = 1'b0;
        #1;
        check("abort.in_ready", in_ready0, 0, 0);
        check("abort.busy", busy0, 0, 0);
        check("abort.busy1", busy1, 0, 0);
        check("abort.ovf", ovf0, 0, 0);
        check("abort.out_valid", out_valid0, 0, 0);
        check("abort.out_re", out_re0, 0, 0);
        check("abort.out_im", out_im0, 0, 0);
        check("abort.out_index", out_index0, 0, 0);
        check("abort.out_last", out_last0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        set_ramp(); run_frame("ramp_after_rst", 1'b0, 1'b1, 1'b0); save(4);

        foreach (tbl[i]) begin
            check($sformatf("tbl%0d.s%0d.d%0d.bin%0d.re", i, tbl[i].scen, tbl[i].dut, tbl[i].bin),
                  res_re[tbl[i].scen][tbl[i].dut][tbl[i].bin], tbl[i].exp_re, tbl[i].tol);
            check($sformatf("tbl%0d.s%0d.d%0d.bin%0d.im", i, tbl[i].scen, tbl[i].dut, tbl[i].bin),
                  res_im[tbl[i].scen][tbl[i].dut][tbl[i].bin], tbl[i].exp_im, tbl[i].tol);
        end
        check("impulse.ovf", res_ovf[0][0], 0, 0);
        check("ramp.ovf", res_ovf[1][0], 0, 0);
        check("ramp_scaled.ovf", res_ovf[1][1], 0, 0);
        check("ovf.flag", res_ovf[2][0], 1, 0);
        check("ovf_scaled.flag", res_ovf[2][1], 0, 0);
        check("impulse2.ovf", res_ovf[3][0], 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
